// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: instruction fetch sequencer for the SAP-2 CPU.
// Reads an opcode byte at the PC, then the number of operand bytes reported
// by the control unit, assembling them little-endian into operand_o.
//
// Build option: define OPFETCH_LEN_TRAP_EN to trap lengths above
// MAX_OPERAND_BYTES into a sticky ERR state. Without it the length is clamped
// and err_o is held at 0.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   start, halt     fetch request (IDLE only), start inhibit
//   pc_load(_val)   PC load in IDLE, takes priority over start
//   opcode_len_i    operand byte count decoded from opcode_o
//   mem_data_i      read data, valid the cycle after mem_rd_o
//   mem_addr_o      read address (0 when not reading)
//   mem_rd_o        read strobe, one cycle per fetched byte
//   pc_o            program counter
//   opcode_o        latched opcode
//   operand_o       assembled operand, byte 0 in the low bits
//   busy_o          high outside IDLE
//   done_o          one-cycle completion pulse
//   err_o           illegal-length flag
module operand_fetch_seq #(
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned MAX_OPERAND_BYTES = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(16'hF000)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    halt,
  input  logic                                    pc_load,
  input  logic [ADDR_WIDTH-1:0]                   pc_load_val,
  input  logic [$clog2(MAX_OPERAND_BYTES+2)-1:0]  opcode_len_i,
  input  logic [DATA_WIDTH-1:0]                   mem_data_i,
  output logic [ADDR_WIDTH-1:0]                   mem_addr_o,
  output logic                                    mem_rd_o,
  output logic [ADDR_WIDTH-1:0]                   pc_o,
  output logic [DATA_WIDTH-1:0]                   opcode_o,
  output logic [MAX_OPERAND_BYTES*DATA_WIDTH-1:0] operand_o,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    err_o
);

  localparam int unsigned LEN_W  = $clog2(MAX_OPERAND_BYTES + 2);
  localparam int unsigned OPND_W = MAX_OPERAND_BYTES * DATA_WIDTH;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_OPERAND_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_REQ,
    S_OP_WAIT,
    S_DECODE,
    S_ARG_REQ,
    S_ARG_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
  logic [OPND_W-1:0]     operand_q, operand_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_rd_d, busy_d, done_d, err_d;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      opcode_q   <= '0;
      operand_q  <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      mem_addr_o <= '0;
      mem_rd_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mem_addr_o <= mem_addr_d;
      mem_rd_o   <= mem_rd_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      err_o      <= err_d;
    end
  end

  // Next-state and datapath updates; outputs are decoded from the next state
  // so that the registered versions line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;

    case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (start && !halt) begin
          state_d   = S_OP_REQ;
          operand_d = '0;
        end
      end

      S_OP_REQ: state_d = S_OP_WAIT;

      S_OP_WAIT: begin
        opcode_d = mem_data_i;
        pc_d     = pc_q + ADDR_WIDTH'(1);
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        idx_d = '0;
`ifdef OPFETCH_LEN_TRAP_EN
        if (opcode_len_i > MAX_LEN) begin
          state_d = S_ERR;
        end else begin
          cnt_d   = opcode_len_i;
          state_d = (opcode_len_i == '0) ? S_DONE : S_ARG_REQ;
        end
`else
        cnt_d   = (opcode_len_i > MAX_LEN) ? MAX_LEN : opcode_len_i;
        state_d = (cnt_d == '0) ? S_DONE : S_ARG_REQ;
`endif
      end

      S_ARG_REQ: state_d = S_ARG_WAIT;

      S_ARG_WAIT: begin
        for (int unsigned i = 0; i < MAX_OPERAND_BYTES; i++) begin
          if (idx_q == LEN_W'(i)) begin
            operand_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_data_i;
          end
        end
        pc_d    = pc_q + ADDR_WIDTH'(1);
        idx_d   = idx_q + LEN_W'(1);
        state_d = ((idx_q + LEN_W'(1)) == cnt_q) ? S_DONE : S_ARG_REQ;
      end

      S_DONE: state_d = S_IDLE;

      // Sticky until reset.
      S_ERR: state_d = S_ERR;

      default: state_d = S_IDLE;
    endcase

    mem_rd_d   = (state_d == S_OP_REQ) || (state_d == S_ARG_REQ);
    mem_addr_d = mem_rd_d ? pc_d : '0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
`ifdef OPFETCH_LEN_TRAP_EN
    err_d      = (state_d == S_ERR);
`else
    err_d      = 1'b0;
`endif
  end

  assign pc_o      = pc_q;
  assign opcode_o  = opcode_q;
  assign operand_o = operand_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Self-checking bench for operand_fetch_seq: directed scenarios plus a
// randomized run against a byte-level reference model.
module tb_operand_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0;
  logic [1:0]  opcode_len_i;
  logic [7:0]  mem_data_i = 8'h0;
  logic [15:0] mem_addr_o;
  logic        mem_rd_o;
  logic [15:0] pc_o;
  logic [7:0]  opcode_o;
  logic [15:0] operand_o;
  logic        busy_o, done_o, err_o;

  logic [7:0]  mem [65536];
  int          cur_len = 0;
  logic [15:0] exp_pc = 16'hF000;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  assign opcode_len_i = 2'(cur_len);

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_o) mem_data_i <= mem[mem_addr_o];

  operand_fetch_seq dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .opcode_len_i(opcode_len_i),
    .mem_data_i(mem_data_i), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
    .pc_o(pc_o), .opcode_o(opcode_o), .operand_o(operand_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Reference model: operand bytes follow the opcode in memory, low byte first.
  function automatic int eff_len(input int len);
    return (len > 2) ? 2 : len;
  endfunction

  function automatic logic [15:0] model_operand(input logic [15:0] pc, input int len);
    logic [15:0] r = 16'h0;
    for (int i = 0; i < eff_len(len); i++) r = r | (16'(mem[16'(pc + 16'(1 + i))]) << (8 * i));
    return r;
  endfunction

  // Pulses start, then watches until one cycle past done (or a 40-cycle bound).
  task automatic run_fetch(output int cyc, output int rds, output int dones);
    cyc = 0; rds = 0; dones = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_rd_o) rds++;
      if (done_o) begin dones++; if (cyc == 0) cyc = k; end
      if (cyc != 0 && k == cyc + 1) break;
    end
  endtask

  task automatic load_pc(input logic [15:0] v);
    @(negedge clk); pc_load = 1'b1; pc_load_val = v;
    @(negedge clk); pc_load = 1'b0;
    exp_pc = v;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    exp_pc = 16'hF000;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (pc_o !== 16'hF000) $display("FAIL rst_pc got %h want F000", pc_o); else pass_cnt++;
    total_cnt++; if (opcode_o !== 8'h00) $display("FAIL rst_opcode got %h want 00", opcode_o); else pass_cnt++;
    total_cnt++; if (operand_o !== 16'h0) $display("FAIL rst_operand got %h want 0000", operand_o); else pass_cnt++;
    total_cnt++; if ({mem_rd_o, busy_o, done_o, err_o} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {mem_rd_o, busy_o, done_o, err_o}); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 16'h0) $display("FAIL rst_addr got %h want 0000", mem_addr_o); else pass_cnt++;
    reset = 1'b1;
    exp_pc = 16'hF000;
  endtask

  task automatic test_one_byte();
    int cyc, rds, dn;
    mem[16'hF000] = 8'h12; mem[16'hF001] = 8'hAA; cur_len = 1;
    run_fetch(cyc, rds, dn);
    total_cnt++; if (opcode_o !== 8'h12) $display("FAIL one_opcode got %h want 12", opcode_o); else pass_cnt++;
    total_cnt++; if (operand_o !== 16'h00AA) $display("FAIL one_operand got %h want 00AA", operand_o); else pass_cnt++;
    total_cnt++; if (pc_o !== 16'hF002) $display("FAIL one_pc got %h want F002", pc_o); else pass_cnt++;
    total_cnt++; if (cyc !== 6) $display("FAIL one_latency got %0d want 6", cyc); else pass_cnt++;
    total_cnt++; if (rds !== 2 || dn !== 1) $display("FAIL one_reads got %0d/%0d want 2/1", rds, dn); else pass_cnt++;
    exp_pc = 16'hF002;
  endtask

  task automatic test_two_byte();
    int cyc, rds, dn;
    load_pc(16'hF000);
    mem[16'hF000] = 8'h30; mem[16'hF001] = 8'h34; mem[16'hF002] = 8'h12; cur_len = 2;
    run_fetch(cyc, rds, dn);
    total_cnt++; if (operand_o !== 16'h1234) $display("FAIL two_operand got %h want 1234", operand_o); else pass_cnt++;
    total_cnt++; if (pc_o !== 16'hF003) $display("FAIL two_pc got %h want F003", pc_o); else pass_cnt++;
    total_cnt++; if (cyc !== 8 || rds !== 3) $display("FAIL two_timing got %0d/%0d want 8/3", cyc, rds); else pass_cnt++;
    exp_pc = 16'hF003;
  endtask

  task automatic test_no_operand_halt();
    int cyc, rds, dn;
    load_pc(16'hF000);
    mem[16'hF000] = 8'h76; cur_len = 0;
    run_fetch(cyc, rds, dn);
    total_cnt++; if (cyc !== 4 || rds !== 1) $display("FAIL nop_timing got %0d/%0d want 4/1", cyc, rds); else pass_cnt++;
    total_cnt++; if (pc_o !== 16'hF001) $display("FAIL nop_pc got %h want F001", pc_o); else pass_cnt++;
    total_cnt++; if (operand_o !== 16'h0) $display("FAIL nop_operand got %h want 0000", operand_o); else pass_cnt++;
    halt = 1'b1; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++; if (busy_o !== 1'b0 || pc_o !== 16'hF001) $display("FAIL halt_idle got busy=%b pc=%h want 0/F001", busy_o, pc_o); else pass_cnt++;
    end
    start = 1'b0; halt = 1'b0;
    exp_pc = 16'hF001;
  endtask

  task automatic test_wrap_load();
    int cyc, rds, dn;
    @(negedge clk); pc_load = 1'b1; pc_load_val = 16'hFFFF; start = 1'b1;
    @(negedge clk); pc_load = 1'b0; start = 1'b0;
    total_cnt++; if (pc_o !== 16'hFFFF) $display("FAIL load_pc got %h want FFFF", pc_o); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (busy_o !== 1'b0 || mem_rd_o !== 1'b0) $display("FAIL load_nofetch got busy=%b rd=%b want 0/0", busy_o, mem_rd_o); else pass_cnt++;
      @(negedge clk);
    end
    mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h5A; cur_len = 1;
    run_fetch(cyc, rds, dn);
    total_cnt++; if (operand_o !== 16'h005A) $display("FAIL wrap_operand got %h want 005A", operand_o); else pass_cnt++;
    total_cnt++; if (pc_o !== 16'h0001) $display("FAIL wrap_pc got %h want 0001", pc_o); else pass_cnt++;
    exp_pc = 16'h0001;
  endtask

  task automatic test_reset_mid();
    int cyc, rds, dn, sawdone;
    load_pc(16'hF000);
    mem[16'hF000] = 8'h31; mem[16'hF001] = 8'hC3; mem[16'hF002] = 8'h9E; cur_len = 2;
    sawdone = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int k = 2; k <= 5; k++) begin @(negedge clk); if (done_o) sawdone++; end
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_rd_o !== 1'b0 || sawdone != 0) $display("FAIL mid_idle got busy=%b done=%b rd=%b early=%0d want 0/0/0/0", busy_o, done_o, mem_rd_o, sawdone); else pass_cnt++;
    total_cnt++; if (pc_o !== 16'hF000) $display("FAIL mid_pc got %h want F000", pc_o); else pass_cnt++;
    total_cnt++; if (operand_o !== 16'h0) $display("FAIL mid_operand got %h want 0000", operand_o); else pass_cnt++;
    reset = 1'b1;
    exp_pc = 16'hF000;
    run_fetch(cyc, rds, dn);
    total_cnt++; if (operand_o !== 16'h9EC3 || pc_o !== 16'hF003 || cyc !== 8) $display("FAIL mid_after got %h/%h/%0d want 9EC3/F003/8", operand_o, pc_o, cyc); else pass_cnt++;
    exp_pc = 16'hF003;
  endtask

  task automatic test_illegal_len();
    int cyc, rds, dn;
    do_reset();
    mem[16'hF000] = 8'hEE; mem[16'hF001] = 8'h11; mem[16'hF002] = 8'h22; cur_len = 3;
    run_fetch(cyc, rds, dn);
`ifdef OPFETCH_LEN_TRAP_EN
    total_cnt++; if (err_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL trap_err got err=%b busy=%b want 1/1", err_o, busy_o); else pass_cnt++;
    total_cnt++; if (dn !== 0 || pc_o !== 16'hF001) $display("FAIL trap_state got done=%0d pc=%h want 0/F001", dn, pc_o); else pass_cnt++;
    do_reset();
    total_cnt++; if (err_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL trap_clear got err=%b busy=%b want 0/0", err_o, busy_o); else pass_cnt++;
`else
    total_cnt++; if (cyc !== 8 || rds !== 3) $display("FAIL clamp_timing got %0d/%0d want 8/3", cyc, rds); else pass_cnt++;
    total_cnt++; if (operand_o !== 16'h2211 || pc_o !== 16'hF003) $display("FAIL clamp_data got %h/%h want 2211/F003", operand_o, pc_o); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL clamp_err got %b want 0", err_o); else pass_cnt++;
    exp_pc = 16'hF003;
`endif
    cur_len = 0;
  endtask

  task automatic test_back_to_back();
    int d[3];
    int n = 0;
    logic [15:0] pc0;
    load_pc(16'h4000);
    pc0 = exp_pc;
    for (int i = 0; i < 8; i++) mem[16'(pc0 + 16'(i))] = 8'($urandom);
    cur_len = 1;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (done_o) begin d[n] = k; n++; end
    end
    start = 1'b0;
    @(negedge clk);
    total_cnt++; if (n !== 3) $display("FAIL b2b_count got %0d want 3", n); else pass_cnt++;
    if (n == 3) begin
      total_cnt++; if (d[1] - d[0] !== 7 || d[2] - d[1] !== 7) $display("FAIL b2b_period got %0d/%0d want 7/7", d[1] - d[0], d[2] - d[1]); else pass_cnt++;
    end
    exp_pc = 16'(pc0 + 16'd6);
    total_cnt++; if (pc_o !== exp_pc || busy_o !== 1'b0) $display("FAIL b2b_pc got %h busy=%b want %h/0", pc_o, busy_o, exp_pc); else pass_cnt++;
    total_cnt++; if (operand_o !== model_operand(16'(pc0 + 16'd4), 1)) $display("FAIL b2b_operand got %h want %h", operand_o, model_operand(16'(pc0 + 16'd4), 1)); else pass_cnt++;
  endtask

  task automatic test_random();
    int cyc, rds, dn, len;
    logic [15:0] p;
    logic [15:0] eo;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) load_pc(($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + 16'($urandom_range(0, 2))) : 16'($urandom));
      p = exp_pc;
      for (int i = 0; i < 4; i++) mem[16'(p + 16'(i))] = 8'($urandom);
`ifdef OPFETCH_LEN_TRAP_EN
      len = $urandom_range(0, 2);
`else
      len = $urandom_range(0, 3);
`endif
      cur_len = len;
      eo = model_operand(p, len);
      run_fetch(cyc, rds, dn);
      exp_pc = 16'(p + 16'(1 + eff_len(len)));
      total_cnt++; if (opcode_o !== mem[p] || operand_o !== eo) $display("FAIL rnd_data it=%0d got %h/%h want %h/%h", it, opcode_o, operand_o, mem[p], eo); else pass_cnt++;
      total_cnt++; if (pc_o !== exp_pc) $display("FAIL rnd_pc it=%0d got %h want %h", it, pc_o, exp_pc); else pass_cnt++;
      total_cnt++; if (cyc !== 4 + 2 * eff_len(len) || rds !== 1 + eff_len(len) || dn !== 1) $display("FAIL rnd_timing it=%0d got %0d/%0d/%0d want %0d/%0d/1", it, cyc, rds, dn, 4 + 2 * eff_len(len), 1 + eff_len(len)); else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_one_byte();
    test_two_byte();
    test_no_operand_halt();
    test_wrap_load();
    test_reset_mid();
    test_illegal_len();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
